fir_interp2: RTL and testbench



---
 rtl/fir_interp2.sv | 179 +++++++++++++++++
 tb/tb_fir_interp2.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_interp2.sv
// rtl/fir_interp2.sv - 2x interpolating 21-tap polyphase low-pass FIR, single time-shared multiplier
//
// Purpose:
//   Each accepted (16,13) input sample produces two (16,12) output samples,
//   even phase first, then odd phase. The even branch uses h[0,2,..,20] over
//   x[0..10]. The odd branch uses h[1,3,..,19] over x[0..9]. Both branches
//   share one 16x16 multiplier and a 32-bit Q28 accumulator, one tap per cycle.
//
// Ports:
//   clk        in   1   rising-edge clock
//   reset_n    in   1   asynchronous active-low reset
//   in_valid   in   1   in_data valid
//   in_ready   out  1   high only while idle (reset value 1)
//   in_data    in  16   signed input sample (16,13)
//   out_valid  out  1   out_data valid, registered (reset value 0)
//   out_ready  in   1   downstream accepts out_data
//   out_data   out 16   signed output sample (16,12), registered (reset value 0)

module fir_interp2 (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MAC_E = 3'd1,
    S_OUT_E = 3'd2,
    S_MAC_O = 3'd3,
    S_OUT_O = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic signed [15:0] r_x [0:10];
  logic signed [31:0] r_acc;
  logic        [3:0]  r_k;
  logic        [15:0] r_out_data;
  logic               r_out_valid;

  logic               w_in_ready;
  logic               w_accept;
  logic               w_last_tap;
  logic        [4:0]  w_coef_idx;
  logic signed [15:0] w_coef;
  logic signed [15:0] w_tap;
  logic signed [31:0] w_prod;
  logic signed [31:0] w_sum;
  logic signed [31:0] w_round;
  logic        [15:0] w_out;
  logic               w_unused_round;

  // The filter is symmetric (h[j] == h[20-j]), so mirrored indices share a value.
  function automatic logic signed [15:0] coef_rom(input logic [4:0] idx);
    case (idx)
      5'd0,  5'd20: coef_rom = -16'sd10;
      5'd1,  5'd19: coef_rom =  16'sd62;
      5'd2,  5'd18: coef_rom =  16'sd84;
      5'd3,  5'd17: coef_rom = -16'sd296;
      5'd4,  5'd16: coef_rom = -16'sd246;
      5'd5,  5'd15: coef_rom =  16'sd954;
      5'd6,  5'd14: coef_rom =  16'sd477;
      5'd7,  5'd13: coef_rom = -16'sd2645;
      5'd8,  5'd12: coef_rom = -16'sd689;
      5'd9,  5'd11: coef_rom =  16'sd10122;
      5'd10:        coef_rom =  16'sd17159;
      default:      coef_rom =  16'sd0;
    endcase
  endfunction

  assign w_in_ready = (r_state == S_IDLE);
  assign w_accept   = w_in_ready && in_valid;
  assign w_last_tap = ((r_state == S_MAC_E) && (r_k == 4'd10)) ||
                      ((r_state == S_MAC_O) && (r_k == 4'd9));

  // Coefficient index is 2k for the even phase and 2k+1 for the odd phase.
  assign w_coef_idx = {r_k, (r_state == S_MAC_O)};
  assign w_coef     = coef_rom(w_coef_idx);

  always_comb begin
    w_tap = 16'sd0;
    for (int i = 0; i < 11; i++) begin
      if (r_k == 4'(i)) begin
        w_tap = r_x[i];
      end
    end
  end

  assign w_prod  = 32'(w_coef) * 32'(w_tap);
  assign w_sum   = r_acc + w_prod;
  // Round half up, then >>> 15; the Q28 -> Q12 shift of 16 less one bit folds in the gain of 2.
  assign w_round = w_sum + 32'sd16384;
  assign w_out   = w_round[30:15];
  assign w_unused_round = ^{w_round[31], w_round[14:0]};

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)                  w_state_nxt = S_MAC_E;
      S_MAC_E: if (r_k == 4'd10)              w_state_nxt = S_OUT_E;
      S_OUT_E: if (out_ready)                 w_state_nxt = S_MAC_O;
      S_MAC_O: if (r_k == 4'd9)               w_state_nxt = S_OUT_O;
      S_OUT_O: if (out_ready)                 w_state_nxt = S_IDLE;
      default:                                w_state_nxt = S_IDLE;
    endcase
  end

  // Delay line, accumulator, tap counter and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 11; i++) begin
        r_x[i] <= 16'sd0;
      end
      r_acc       <= 32'sd0;
      r_k         <= 4'd0;
      r_out_data  <= 16'd0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_x[0] <= in_data;
            for (int i = 1; i < 11; i++) begin
              r_x[i] <= r_x[i-1];
            end
            r_acc <= 32'sd0;
            r_k   <= 4'd0;
          end
        end
        S_MAC_E, S_MAC_O: begin
          if (w_last_tap) begin
            // Final tap goes straight into the rounder; acc itself is not updated.
            r_out_data  <= w_out;
            r_out_valid <= 1'b1;
          end else begin
            r_acc <= w_sum;
            r_k   <= r_k + 4'd1;
          end
        end
        S_OUT_E: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_acc       <= 32'sd0;
            r_k         <= 4'd0;
          end
        end
        S_OUT_O: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_fir_interp2.sv
// tb/tb_fir_interp2.sv - self-checking bench for fir_interp2

module tb_fir_interp2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = 16'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;

  fir_interp2 dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [15:0] din;
    int          exp_e;
    int          exp_o;
    bit          chk;
    int          stall;
  } vec_t;

  vec_t vecs[$];

  int h [0:20] = '{-10, 62, 84, -296, -246, 954, 477, -2645, -689, 10122, 17159,
                   10122, -689, -2645, 477, 954, -246, -296, 84, 62, -10};
  int imp [0:21] = '{-2, 16, 21, -74, -61, 239, 119, -661, -172, 2531, 4290,
                     2531, -172, -661, 119, 239, -61, -74, 21, 16, -2, 0};
  int mx [0:10];

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int round_out(input longint acc);
    longint      t;
    logic [15:0] b;
    t = (acc + 64'sd16384) >>> 15;
    b = t[15:0];
    return int'($signed(b));
  endfunction

  task automatic send(input logic [15:0] d, input int idle, output int acc_cyc);
    int n = 0;
    in_valid = 1'b0;
    repeat (idle) @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("send_in_ready_wait", {31'd0, in_ready}, 1);
    @(posedge clk);
    @(negedge clk);
    acc_cyc  = cyc;
    in_valid = 1'b0;
    in_data  = 16'($urandom);
  endtask

  task automatic wait_valid(input string name, output int seen_cyc);
    int n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, out_valid}, 1);
    seen_cyc = cyc;
  endtask

  task automatic run_vec(input vec_t v, output int acc_cyc);
    int          a, e, hs, o;
    logic [15:0] held;
    send(v.din, 0, a);
    acc_cyc = a;
    wait_valid("even_valid_wait", e);
    check("even_latency", e - a, 11);
    if (v.chk) check("even_data", $signed(out_data), v.exp_e);
    if (v.stall > 0) begin
      out_ready = 1'b0;
      held = out_data;
      for (int s = 0; s < v.stall; s++) begin
        @(posedge clk);
        @(negedge clk);
        check("stall_out_valid", {31'd0, out_valid}, 1);
        check("stall_out_data", $signed(out_data), $signed(held));
        check("stall_in_ready", {31'd0, in_ready}, 0);
      end
      out_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    hs = cyc;
    check("even_valid_drop", {31'd0, out_valid}, 0);
    wait_valid("odd_valid_wait", o);
    check("odd_latency", o - hs, 10);
    if (v.chk) check("odd_data", $signed(out_data), v.exp_o);
    @(posedge clk);
    @(negedge clk);
    check("odd_valid_drop", {31'd0, out_valid}, 0);
    check("in_ready_after_odd", {31'd0, in_ready}, 1);
  endtask

  task automatic run_table();
    int a, prev_a, prev_stall;
    prev_a = 0;
    prev_stall = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i], a);
      if (i > 0) check("input_period", a - prev_a, 24 + prev_stall);
      prev_a = a;
      prev_stall = vecs[i].stall;
    end
  endtask

  task automatic fill_impulse();
    vec_t v;
    vecs.delete();
    for (int i = 0; i < 12; i++) begin
      v.din   = (i == 0) ? 16'h2000 : 16'h0000;
      v.exp_e = (i < 11) ? imp[2*i] : 0;
      v.exp_o = (i < 11) ? imp[2*i+1] : 0;
      v.chk   = 1'b1;
      v.stall = 0;
      vecs.push_back(v);
    end
  endtask

  task automatic get_rand(output logic [15:0] d);
    int n = 0;
    bit got = 1'b0;
    d = 16'd0;
    while (!got && n < 300) begin
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 16'($urandom);
      if (out_valid && out_ready) begin
        d = out_data;
        got = 1'b1;
      end
      @(negedge clk);
      n++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("rand_output_wait", {31'd0, got}, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1);
  end

  initial begin
    vec_t        v;
    int          a;
    logic [15:0] d;
    longint      acc_e, acc_o;

    // Reset held with random inputs.
    reset_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 16'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      #1;
      check("reset_out_valid", {31'd0, out_valid}, 0);
      check("reset_out_data", $signed(out_data), 0);
      check("reset_in_ready", {31'd0, in_ready}, 1);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    reset_n   = 1'b1;
    @(negedge clk);
    check("post_reset_in_ready", {31'd0, in_ready}, 1);

    // Impulse response.
    fill_impulse();
    run_table();

    // DC with a 5-cycle stall on one even output.
    vecs.delete();
    for (int i = 0; i < 20; i++) begin
      v.din   = 16'h2000;
      v.exp_e = 4098;
      v.exp_o = 4099;
      v.chk   = (i >= 10);
      v.stall = (i == 12) ? 5 : 0;
      vecs.push_back(v);
    end
    run_table();

    // Reset in the middle of the even MAC.
    send(16'h7FFF, 0, a);
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midreset_out_valid", {31'd0, out_valid}, 0);
    check("midreset_out_data", $signed(out_data), 0);
    check("midreset_in_ready", {31'd0, in_ready}, 1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      check("midreset_no_output", {31'd0, out_valid}, 0);
    end
    fill_impulse();
    run_table();

    // Random data and handshakes against a polyphase model.
    for (int k = 0; k < 11; k++) mx[k] = 0;
    for (int i = 0; i < 500; i++) begin
      d = 16'($urandom);
      send(d, $urandom_range(0, 2), a);
      for (int k = 10; k > 0; k--) mx[k] = mx[k-1];
      mx[0] = int'($signed(d));
      acc_e = 0;
      acc_o = 0;
      for (int k = 0; k < 11; k++) acc_e += longint'(h[2*k]) * longint'(mx[k]);
      for (int k = 0; k < 10; k++) acc_o += longint'(h[2*k+1]) * longint'(mx[k]);
      get_rand(d);
      check("rand_even_data", $signed(d), round_out(acc_e));
      get_rand(d);
      check("rand_odd_data", $signed(d), round_out(acc_o));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
